// File: rtl/relm_div_seq_if.sv
// relm_div_seq_if
// Host-side bundle for the sequential divider.
//   start_in  : request a division (honoured only while busy_out is low)
//   signed_in : 1 = two's-complement operands, captured with start_in
//   n_in/d_in : dividend / divisor, captured with start_in
//   busy_out  : a division is in flight
//   done_out  : one-cycle pulse, q_out/r_out/dz_out valid
//   q_out     : quotient, held until the next done pulse
//   r_out     : remainder, held until the next done pulse
//   dz_out    : divisor was zero for the shown result
// master = host side, slave = divider side.
interface relm_div_seq_if #(
    parameter int WD = 32
);
    logic          start_in;
    logic          signed_in;
    logic [WD-1:0] n_in;
    logic [WD-1:0] d_in;
    logic          busy_out;
    logic          done_out;
    logic [WD-1:0] q_out;
    logic [WD-1:0] r_out;
    logic          dz_out;

    modport master (
        output start_in, signed_in, n_in, d_in,
        input  busy_out, done_out, q_out, r_out, dz_out
    );

    modport slave (
        input  start_in, signed_in, n_in, d_in,
        output busy_out, done_out, q_out, r_out, dz_out
    );
endinterface

// File: rtl/relm_div_seq.sv
// relm_div_seq
// Multi-cycle restoring divider retiring SD quotient bits per cycle.
// Operands are reduced to magnitudes at start, the quotient is built in
// the dividend shift register, and signs are reapplied in a final FIX
// cycle (truncating division: remainder takes the dividend's sign).
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : relm_div_seq_if slave (start/busy/done handshake, operands,
//         quotient, remainder, divide-by-zero flag)
// Parameters: WD operand width, SD quotient bits per iteration (1..4,
// WD divisible by SD). Latency from start edge to done pulse: WD/SD+1.
module relm_div_seq #(
    parameter int WD = 32,
    parameter int SD = 2
) (
    input  logic            clk,
    input  logic            rst,
    relm_div_seq_if.slave   bus
);
    localparam int K  = WD / SD;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int NM = 1 << SD;
    localparam int XW = WD + SD;

    generate
        if (SD < 1 || SD > 4 || (WD % SD) != 0) begin : g_bad_param
            $error("relm_div_seq: SD must be 1..4 and divide WD");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t          state_reg, state_next;
    logic            load;

    logic [WD-1:0]   n_reg;        // dividend magnitude, then quotient
    logic [WD-1:0]   r_reg;        // partial remainder
    logic [WD-1:0]   n_orig_reg;   // raw dividend for the divide-by-zero result
    logic            sign_q_reg;
    logic            sign_r_reg;
    logic            dz_reg;
    logic [CW-1:0]   cnt_reg;
    logic [WD-1:0]   q_out_reg;
    logic [WD-1:0]   r_out_reg;
    logic            dz_out_reg;

    logic [XW-1:0]   mult_reg  [NM];
    logic [XW-1:0]   mult_calc [NM];

    // Operand magnitudes; unsigned mode passes the operands through.
    logic            neg_n, neg_d;
    logic [WD-1:0]   n_abs, d_abs;

    assign neg_n = bus.signed_in & bus.n_in[WD-1];
    assign neg_d = bus.signed_in & bus.d_in[WD-1];
    assign n_abs = neg_n ? (~bus.n_in + 1'b1) : bus.n_in;
    assign d_abs = neg_d ? (~bus.d_in + 1'b1) : bus.d_in;

    // Multiples bank D*m, one register per digit value. Width XW keeps
    // (2^WD-1)*(2^SD-1) exact. Entry 0 is always zero.
    generate
        for (genvar gi = 0; gi < NM; gi++) begin : g_mult
            assign mult_calc[gi] = {{SD{1'b0}}, d_abs} * XW'(gi);

            always_ff @(posedge clk) begin
                if (rst) begin
                    mult_reg[gi] <= '0;
                end else if (load) begin
                    mult_reg[gi] <= mult_calc[gi];
                end
            end
        end
    endgenerate

    // One restoring step: bring in SD dividend bits, pick the largest
    // multiple that fits. Multiples are monotonic in m, so the last
    // passing compare is the largest digit (all pass when D=0).
    logic [XW-1:0]   r_ext;
    logic [XW-1:0]   sub;
    logic [XW-1:0]   diff;
    logic [SD-1:0]   digit;
    logic [WD-1:0]   r_new;
    logic [XW-1:0]   n_cat;
    logic [WD-1:0]   n_shift;

    assign r_ext = {r_reg, n_reg[WD-1 -: SD]};

    always_comb begin
        digit = '0;
        sub   = '0;
        for (int m = 1; m < NM; m++) begin
            if (mult_reg[m] <= r_ext) begin
                digit = m[SD-1:0];
                sub   = mult_reg[m];
            end
        end
    end

    assign diff    = r_ext - sub;
    assign r_new   = diff[WD-1:0];
    assign n_cat   = {n_reg, digit};
    assign n_shift = n_cat[WD-1:0];

    // Sign restoration and special cases. Signed overflow (MIN / -1)
    // falls out of the magnitude path: |MIN| = MIN, quotient MIN, sign
    // unchanged.
    logic [WD-1:0]   q_fix, r_fix;

    always_comb begin
        q_fix = sign_q_reg ? (~n_reg + 1'b1) : n_reg;
        r_fix = sign_r_reg ? (~r_reg + 1'b1) : r_reg;
        if (dz_reg) begin
            // sign_r_reg is exactly "signed mode and dividend negative"
            q_fix = sign_r_reg ? WD'(1) : '1;
            r_fix = n_orig_reg;
        end
    end

    // FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start_in) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                if (bus.start_in) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            n_reg      <= '0;
            r_reg      <= '0;
            n_orig_reg <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            dz_reg     <= 1'b0;
            cnt_reg    <= '0;
            q_out_reg  <= '0;
            r_out_reg  <= '0;
            dz_out_reg <= 1'b0;
        end else begin
            if (load) begin
                n_reg      <= n_abs;
                r_reg      <= '0;
                n_orig_reg <= bus.n_in;
                sign_q_reg <= neg_n ^ neg_d;
                sign_r_reg <= neg_n;
                dz_reg     <= (bus.d_in == '0);
                cnt_reg    <= CW'(K - 1);
            end else if (state_reg == RUN) begin
                n_reg <= n_shift;
                r_reg <= r_new;
                if (cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end else if (state_reg == FIX) begin
                q_out_reg  <= q_fix;
                r_out_reg  <= r_fix;
                dz_out_reg <= dz_reg;
            end
        end
    end

    assign bus.busy_out = (state_reg == RUN) || (state_reg == FIX);
    assign bus.done_out = (state_reg == DONE);
    assign bus.q_out    = q_out_reg;
    assign bus.r_out    = r_out_reg;
    assign bus.dz_out   = dz_out_reg;
endmodule

// File: tb/tb_relm_div_seq.sv
// tb_relm_div_seq
// Scoreboarded bench: every launched division pushes its reference result,
// which is popped and compared when done_out pulses. Covers reset, unsigned
// and signed division, divide-by-zero, signed overflow, busy-start drop,
// back-to-back start, mid-operation reset and a random sweep over three
// other parameter sets (latency 33, 9, 9).
module tb_relm_div_seq;
    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } res_t;

    res_t sb[$];
    res_t sb1[$];
    res_t sb4[$];
    res_t sb16[$];

    relm_div_seq_if #(.WD(32)) bus();
    relm_div_seq_if #(.WD(32)) bus1();
    relm_div_seq_if #(.WD(32)) bus4();
    relm_div_seq_if #(.WD(16)) bus16();

    relm_div_seq #(.WD(32), .SD(2)) dut     (.clk(clk), .rst(rst), .bus(bus));
    relm_div_seq #(.WD(32), .SD(1)) dut_sd1 (.clk(clk), .rst(rst), .bus(bus1));
    relm_div_seq #(.WD(32), .SD(4)) dut_sd4 (.clk(clk), .rst(rst), .bus(bus4));
    relm_div_seq #(.WD(16), .SD(2)) dut_w16 (.clk(clk), .rst(rst), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: truncating division, remainder follows dividend.
    function automatic res_t ref32(input logic s, input logic [31:0] n, input logic [31:0] d);
        res_t e;
        logic signed [31:0] sn, sdv;
        sn  = n;
        sdv = d;
        e.dz = (d == 32'd0);
        if (d == 32'd0) begin
            e.q = (s && n[31]) ? 32'd1 : 32'hFFFF_FFFF;
            e.r = n;
        end else if (s && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else if (s) begin
            e.q = sn / sdv;
            e.r = sn % sdv;
        end else begin
            e.q = n / d;
            e.r = n % d;
        end
        return e;
    endfunction

    function automatic res_t ref16(input logic s, input logic [15:0] n, input logic [15:0] d);
        res_t e;
        logic signed [15:0] sn, sdv;
        logic [15:0] q, r;
        sn  = n;
        sdv = d;
        e.dz = (d == 16'd0);
        if (d == 16'd0) begin
            q = (s && n[15]) ? 16'd1 : 16'hFFFF;
            r = n;
        end else if (s && n == 16'h8000 && d == 16'hFFFF) begin
            q = 16'h8000;
            r = 16'd0;
        end else if (s) begin
            q = sn / sdv;
            r = sn % sdv;
        end else begin
            q = n / d;
            r = n % d;
        end
        e.q = {16'd0, q};
        e.r = {16'd0, r};
        return e;
    endfunction

    // Drive start for one edge (caller is away from the edge); push expected.
    task automatic issue(input logic s, input logic [31:0] n, input logic [31:0] d);
        bus.start_in  = 1'b1;
        bus.signed_in = s;
        bus.n_in      = n;
        bus.d_in      = d;
        sb.push_back(ref32(s, n, d));
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        bus.n_in     = 32'hDEAD_BEEF;
        bus.d_in     = 32'h0BAD_F00D;
    endtask

    // Wait for done (lat0 edges already elapsed since the start edge).
    task automatic wait_result(input string name, input int exp_lat, input int lat0);
        int   lat;
        logic got;
        res_t e;
        lat = lat0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done_out) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s timeout: no done after %0d cycles, required %0d", name, lat, exp_lat);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            if ({bus.q_out, bus.r_out, bus.dz_out} !== {e.q, e.r, e.dz}) begin
                bad++;
                $display("FAIL %s result: got q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
                         name, bus.q_out, bus.r_out, bus.dz_out, e.q, e.r, e.dz);
            end
            total++;
            if (lat !== exp_lat) begin
                bad++;
                $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
            end
            $display("txn %s q=%h r=%h dz=%b lat=%0d", name, bus.q_out, bus.r_out, bus.dz_out, lat);
        end
    endtask

    task automatic run_op(input string name, input logic s, input logic [31:0] n, input logic [31:0] d);
        @(negedge clk);
        issue(s, n, d);
        wait_result(name, 17, 0);
    endtask

    task automatic count_no_done(input string name, input int cycles);
        int dones;
        dones = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.done_out) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL %s spurious done pulses: got %0d, required 0", name, dones);
        end
    endtask

    task automatic test_reset;
        bus.start_in   = 1'b0; bus.signed_in   = 1'b0; bus.n_in   = '0; bus.d_in   = '0;
        bus1.start_in  = 1'b0; bus1.signed_in  = 1'b0; bus1.n_in  = '0; bus1.d_in  = '0;
        bus4.start_in  = 1'b0; bus4.signed_in  = 1'b0; bus4.n_in  = '0; bus4.d_in  = '0;
        bus16.start_in = 1'b0; bus16.signed_in = 1'b0; bus16.n_in = '0; bus16.d_in = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.busy_out, bus.done_out, bus.q_out, bus.r_out, bus.dz_out} !== 67'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b, required all zero",
                     bus.busy_out, bus.done_out, bus.q_out, bus.r_out, bus.dz_out);
        end
        $display("txn reset busy=%b done=%b q=%h r=%h", bus.busy_out, bus.done_out, bus.q_out, bus.r_out);
        rst = 1'b0;
    endtask

    task automatic test_unsigned;
        run_op("unsigned_100_7", 1'b0, 32'd100, 32'd7);
        run_op("unsigned_max_3", 1'b0, 32'hFFFF_FFFF, 32'd3);
        run_op("unsigned_small_big", 1'b0, 32'd5, 32'hF000_0000);
    endtask

    task automatic test_signed;
        run_op("signed_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("signed_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op("signed_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        run_op("unsigned_neg_bits", 1'b0, 32'hFFFF_FFF9, 32'd2);
    endtask

    task automatic test_special;
        run_op("dz_unsigned", 1'b0, 32'd5, 32'd0);
        run_op("dz_signed_neg", 1'b1, 32'hFFFF_FFFB, 32'd0);
        run_op("dz_signed_pos", 1'b1, 32'd5, 32'd0);
        run_op("signed_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_busy_start;
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        bus.start_in = 1'b1;
        bus.n_in     = 32'd9;
        bus.d_in     = 32'd3;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        wait_result("busy_start_ignored", 17, 5);
        count_no_done("busy_start_no_second", 25);
    endtask

    task automatic test_back_to_back;
        run_op("b2b_first", 1'b0, 32'd100, 32'd7);
        issue(1'b0, 32'd9, 32'd3);   // driven during the DONE cycle
        wait_result("b2b_second", 17, 0);
        count_no_done("b2b_no_extra", 22);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({bus.busy_out, bus.done_out, bus.q_out, bus.r_out, bus.dz_out} !== 67'd0) begin
            bad++;
            $display("FAIL reset_mid_state: got busy=%b done=%b q=%h r=%h dz=%b, required all zero",
                     bus.busy_out, bus.done_out, bus.q_out, bus.r_out, bus.dz_out);
        end
        $display("txn reset_mid busy=%b q=%h r=%h", bus.busy_out, bus.q_out, bus.r_out);
        rst = 1'b0;
        sb.delete();
        count_no_done("reset_mid_no_done", 25);
        run_op("after_reset", 1'b0, 32'd1000, 32'd10);
    endtask

    task automatic test_sweep(input int nvec);
        logic        s, g1, g4, g16;
        logic [31:0] n, d;
        logic [15:0] n16, d16;
        int          sel, cyc;
        res_t        e;
        for (int i = 0; i < nvec; i++) begin
            s   = 1'($urandom_range(0, 1));
            n   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) d = 32'd0;
            else if (sel <= 2) d = 32'($urandom_range(1, 15));
            else d = $urandom >> $urandom_range(0, 31);
            if (s && $urandom_range(0, 1) == 1) d = -d;
            n16 = n[15:0];
            d16 = d[15:0];
            if (sel == 3) begin
                n = 32'h8000_0000; d = 32'hFFFF_FFFF;
                n16 = 16'h8000;    d16 = 16'hFFFF;
            end
            sb1.push_back(ref32(s, n, d));
            sb4.push_back(ref32(s, n, d));
            sb16.push_back(ref16(s, n16, d16));
            @(negedge clk);
            bus1.start_in  = 1'b1; bus1.signed_in  = s; bus1.n_in  = n;   bus1.d_in  = d;
            bus4.start_in  = 1'b1; bus4.signed_in  = s; bus4.n_in  = n;   bus4.d_in  = d;
            bus16.start_in = 1'b1; bus16.signed_in = s; bus16.n_in = n16; bus16.d_in = d16;
            @(posedge clk);
            #1;
            bus1.start_in = 1'b0; bus4.start_in = 1'b0; bus16.start_in = 1'b0;
            g1 = 1'b0; g4 = 1'b0; g16 = 1'b0;
            for (cyc = 1; cyc <= 40 && !(g1 && g4 && g16); cyc++) begin
                @(posedge clk);
                #1;
                if (!g1 && bus1.done_out) begin
                    g1 = 1'b1;
                    e = sb1.pop_front();
                    total += 2;
                    if ({bus1.q_out, bus1.r_out, bus1.dz_out} !== {e.q, e.r, e.dz}) begin
                        bad++;
                        $display("FAIL sweep_sd1 s=%b n=%h d=%h: got q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
                                 s, n, d, bus1.q_out, bus1.r_out, bus1.dz_out, e.q, e.r, e.dz);
                    end
                    if (cyc !== 33) begin
                        bad++;
                        $display("FAIL sweep_sd1_latency: got %0d, required 33", cyc);
                    end
                end
                if (!g4 && bus4.done_out) begin
                    g4 = 1'b1;
                    e = sb4.pop_front();
                    total += 2;
                    if ({bus4.q_out, bus4.r_out, bus4.dz_out} !== {e.q, e.r, e.dz}) begin
                        bad++;
                        $display("FAIL sweep_sd4 s=%b n=%h d=%h: got q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
                                 s, n, d, bus4.q_out, bus4.r_out, bus4.dz_out, e.q, e.r, e.dz);
                    end
                    if (cyc !== 9) begin
                        bad++;
                        $display("FAIL sweep_sd4_latency: got %0d, required 9", cyc);
                    end
                end
                if (!g16 && bus16.done_out) begin
                    g16 = 1'b1;
                    e = sb16.pop_front();
                    total += 2;
                    if ({16'd0, bus16.q_out, 16'd0, bus16.r_out, bus16.dz_out} !== {e.q, e.r, e.dz}) begin
                        bad++;
                        $display("FAIL sweep_w16 s=%b n=%h d=%h: got q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
                                 s, n16, d16, bus16.q_out, bus16.r_out, bus16.dz_out, e.q[15:0], e.r[15:0], e.dz);
                    end
                    if (cyc !== 9) begin
                        bad++;
                        $display("FAIL sweep_w16_latency: got %0d, required 9", cyc);
                    end
                end
            end
            if (!g1)  begin total++; bad++; void'(sb1.pop_front());  $display("FAIL sweep_sd1_timeout: got no done, required done at 33"); end
            if (!g4)  begin total++; bad++; void'(sb4.pop_front());  $display("FAIL sweep_sd4_timeout: got no done, required done at 9"); end
            if (!g16) begin total++; bad++; void'(sb16.pop_front()); $display("FAIL sweep_w16_timeout: got no done, required done at 9"); end
            $display("txn sweep %0d s=%b n=%h d=%h", i, s, n, d);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        test_sweep(300);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
